// File: rtl/spike_window_decoder.sv
// Counts rising edges per output-neuron spike line over a fixed window, then reports counts, winner and tie.
// Latency: start sampled at t -> WINDOW_CYCLES sampled cycles -> result_valid at t+WINDOW_CYCLES+1.
// Backpressure: result held stable in DONE until result_ready; start is ignored outside IDLE.
module spike_window_decoder #(
    parameter  int N_OUT         = 2,
    parameter  int CNT_W         = 8,
    parameter  int WINDOW_CYCLES = 64,
    localparam int WIN_W         = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int WC_W          = $clog2(WINDOW_CYCLES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_OUT-1:0]       spike_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [N_OUT*CNT_W-1:0] spike_count,
    output logic [WIN_W-1:0]       winner,
    output logic                   tie
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW_CYCLES - 1);

    state_t           state;
    logic [N_OUT-1:0] prev;
    logic [WC_W-1:0]  wc_q;
    logic [CNT_W-1:0] cnt_q   [N_OUT];
    logic [CNT_W-1:0] cnt_nxt [N_OUT];
    logic [CNT_W-1:0] best_cnt;
    logic [WIN_W-1:0] best_idx;
    logic             dup;

    // Next counts include this cycle's edges so the final window cycle feeds the winner/tie decision.
    always_comb begin
        best_idx = '0;
        dup      = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (spike_in[i] && !prev[i] && cnt_q[i] != CNT_MAX)
                cnt_nxt[i] = cnt_q[i] + 1'b1;
        end
        best_cnt = cnt_nxt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (cnt_nxt[i] > best_cnt) begin
                best_cnt = cnt_nxt[i];
                best_idx = WIN_W'(i);
                dup      = 1'b0;
            end else if (cnt_nxt[i] == best_cnt) begin
                dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= '0;
            tie          <= 1'b0;
            prev         <= '0;
            wc_q         <= '0;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
        end else begin
            prev <= spike_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        wc_q  <= '0;
                        for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
                    end
                end
                COUNT: begin
                    for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_nxt[i];
                    wc_q <= wc_q + 1'b1;
                    if (wc_q == WC_LAST) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        winner       <= best_idx;
                        tie          <= dup;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_pack
        assign spike_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Scoreboard bench for spike_window_decoder: a reference edge counter predicts each window's result.
module tb_spike_window_decoder;

    localparam int N_OUT = 2;
    localparam int CNT_W = 3;
    localparam int WIN   = 16;
    localparam int WIN_W = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [N_OUT-1:0]       spike_in;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [N_OUT*CNT_W-1:0] spike_count;
    logic [WIN_W-1:0]       winner;
    logic                   tie;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N_OUT*CNT_W-1:0] cnt;
        logic [WIN_W-1:0]       win;
        logic                   tie;
    } exp_t;

    exp_t             exp_q[$];
    logic [N_OUT-1:0] pat [WIN];
    logic [N_OUT-1:0] pre;

    always #5 clk = ~clk;

    spike_window_decoder #(
        .N_OUT(N_OUT), .CNT_W(CNT_W), .WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .spike_count(spike_count), .winner(winner), .tie(tie)
    );

    task automatic run_window();
        int               cnt [N_OUT];
        int               mx;
        int               nmax;
        logic [N_OUT-1:0] prev_m;
        exp_t             e;
        @(negedge clk);
        start    = 1'b1;
        spike_in = pre;
        prev_m   = pre;
        @(posedge clk);
        for (int i = 0; i < N_OUT; i++) cnt[i] = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (k == WIN - 1) begin
                checks++;
                if (result_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL early_valid: valid=%b busy=%b, required valid=0 busy=1", result_valid, busy);
                end
            end
            start    = (k % 5 == 3);
            spike_in = pat[k];
            for (int i = 0; i < N_OUT; i++)
                if (pat[k][i] && !prev_m[i] && cnt[i] < (1 << CNT_W) - 1) cnt[i]++;
            prev_m = pat[k];
            @(posedge clk);
        end
        start = 1'b0;
        mx = 0;
        for (int i = 0; i < N_OUT; i++) if (cnt[i] > mx) mx = cnt[i];
        nmax  = 0;
        e.win = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (cnt[i] == mx) begin
                nmax++;
                e.win = WIN_W'(i);
            end
            e.cnt[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
        end
        e.tie = (nmax > 1);
        exp_q.push_back(e);
    endtask

    task automatic collect_result(input string name, input int hold);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (result_valid !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (result_valid !== 1'b1 || waited != 0) begin
            errors++;
            $display("FAIL %s latency: valid=%b after %0d extra cycles, required valid=1 at t+%0d", name, result_valid, waited, WIN + 1);
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (spike_count !== e.cnt) begin
            errors++;
            $display("FAIL %s counts: got %h, required %h", name, spike_count, e.cnt);
        end
        checks++;
        if (winner !== e.win || tie !== e.tie) begin
            errors++;
            $display("FAIL %s winner/tie: got %0d/%b, required %0d/%b", name, winner, tie, e.win, e.tie);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_done: got %b, required 1", name, busy);
        end
        for (int h = 0; h < hold; h++) begin
            start    = h[0];
            spike_in = N_OUT'($urandom);
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || spike_count !== e.cnt ||
                winner !== e.win || tie !== e.tie) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b busy=%b cnt=%h win=%0d tie=%b, required 1 1 %h %0d %b",
                         name, h, result_valid, busy, spike_count, winner, tie, e.cnt, e.win, e.tie);
            end
        end
        result_ready = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || spike_count !== e.cnt) begin
            errors++;
            $display("FAIL %s release: valid=%b busy=%b cnt=%h, required 0 0 %h", name, result_valid, busy, spike_count, e.cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spike_in = N_OUT'($urandom);
            start    = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || spike_count !== '0 || winner !== '0 || tie !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%b cnt=%h win=%0d tie=%b, required all 0", busy, result_valid, spike_count, winner, tie);
        end
        rst      = 1'b0;
        start    = 1'b0;
        spike_in = '0;
    endtask

    task automatic test_basic();
        pre = '0;
        for (int k = 0; k < WIN; k++) pat[k] = {1'(k == 2 || k == 9), 1'(k % 4 == 0)};
        run_window();
        collect_result("basic", 0);
        for (int k = 0; k < WIN; k++) pat[k] = {1'(k == 0 || k == 3 || k == 6), 1'(k == 8)};
        run_window();
        collect_result("winner1", 0);
    endtask

    task automatic test_tie_levels();
        pre = '0;
        for (int k = 0; k < WIN; k++) pat[k] = {1'(k != 5 && k != 11), 1'(k == 1 || k == 7 || k == 13)};
        run_window();
        collect_result("tie_levels", 0);
        pre = 2'b10;
        for (int k = 0; k < WIN; k++) pat[k] = {1'b1, 1'(k == 3 || k == 10)};
        run_window();
        collect_result("held_high", 0);
        pre = '0;
        for (int k = 0; k < WIN; k++) pat[k] = '0;
        run_window();
        collect_result("all_zero", 0);
    endtask

    task automatic test_saturation();
        pre = '0;
        for (int k = 0; k < WIN; k++) pat[k] = {1'(k == 1 || k == 5 || k == 9), 1'(k % 2 == 0)};
        run_window();
        collect_result("saturation", 0);
    endtask

    task automatic test_backpressure();
        pre          = '0;
        result_ready = 1'b0;
        for (int k = 0; k < WIN; k++) pat[k] = {1'(k % 3 == 0), 1'(k == 4)};
        run_window();
        collect_result("backpressure", 20);
        pre = '0;
        for (int k = 0; k < WIN; k++) pat[k] = {1'b0, 1'(k == 6)};
        run_window();
        collect_result("fresh_window", 0);
    endtask

    task automatic test_abort();
        bit rose = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        spike_in = '0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start    = 1'b0;
            spike_in = {N_OUT{k[0]}};
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || spike_count !== '0 || winner !== '0 || tie !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b valid=%b cnt=%h win=%0d tie=%b, required all 0", busy, result_valid, spike_count, winner, tie);
        end
        for (int k = 0; k < 30; k++) begin
            spike_in = N_OUT'($urandom);
            @(negedge clk);
            if (result_valid !== 1'b0 || busy !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL abort_quiet: valid/busy rose after abort, required both stay 0");
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        spike_in     = '0;
        result_ready = 1'b1;
        pre          = '0;
        test_reset();
        test_basic();
        test_tie_levels();
        test_saturation();
        test_backpressure();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
